micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer_pkg.sv | 32 +++
 rtl/opcode_dispatch_map.sv | 41 ++++
 rtl/micro_sequencer.sv | 121 ++++++++++++
 tb/tb_micro_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer: TY encodings, FSM states,
// address width, control-store depth and the address increment helper.
package micro_sequencer_pkg;

  localparam int ADDR_W      = 6;
  localparam int STORE_DEPTH = 36;
  localparam int OPCODE_W    = 4;

  localparam logic [ADDR_W-1:0] STORE_LAST = ADDR_W'(STORE_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = '0;

  // TY field of a control word selects where the next address comes from.
  typedef enum logic [1:0] {
    TY_NA       = 2'b00,
    TY_COND     = 2'b01,
    TY_INC      = 2'b10,
    TY_DISPATCH = 2'b11
  } selType_e;

  typedef enum logic [1:0] {
    ST_PRIME = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_HALT  = 2'b11
  } seqState_e;

  // 6-bit arithmetic wraps 63 back to 0.
  function automatic logic [ADDR_W-1:0] incAddr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/opcode_dispatch_map.sv
// Combinational dispatch ROM: maps an instruction opcode to the first
// microword of its routine, flagging opcodes with no routine as invalid.
module opcode_dispatch_map
  import micro_sequencer_pkg::*;
(
  input  logic [OPCODE_W-1:0] Opcode,
  output logic [ADDR_W-1:0]   DispatchAddress,
  output logic                DispatchValid
);

  logic [ADDR_W-1:0] tableAddr;
  logic              tableHit;

  // Routines are two words apart starting at word 8; opcodes 12..15 are unused.
  always_comb begin
    tableAddr = ADDR_ZERO;
    tableHit  = 1'b1;
    case (Opcode)
      4'd0:    tableAddr = 6'd8;
      4'd1:    tableAddr = 6'd10;
      4'd2:    tableAddr = 6'd12;
      4'd3:    tableAddr = 6'd14;
      4'd4:    tableAddr = 6'd16;
      4'd5:    tableAddr = 6'd18;
      4'd6:    tableAddr = 6'd20;
      4'd7:    tableAddr = 6'd22;
      4'd8:    tableAddr = 6'd24;
      4'd9:    tableAddr = 6'd26;
      4'd10:   tableAddr = 6'd28;
      4'd11:   tableAddr = 6'd30;
      default: tableHit  = 1'b0;
    endcase
  end

  // An entry pointing past the populated store is treated as unmapped.
  always_comb begin
    DispatchValid   = tableHit && (tableAddr <= STORE_LAST);
    DispatchAddress = DispatchValid ? tableAddr : ADDR_ZERO;
  end

endmodule

// File: rtl/micro_sequencer.sv
// Zero-bubble micro-sequencer: ControlAddress feeds a registered control store
// so the store word and CAR update on the same edge.
// Optional single-step mode is enabled by defining MSEQ_SINGLE_STEP_EN.
//
// Handshake: a word with MemRequest=1 commits only in the cycle MemReady=1;
// until then CAR holds and MicroValid stays low.
module micro_sequencer
  import micro_sequencer_pkg::*;
(
  input  logic                ClockInput,
  input  logic                ResetInputN,
  input  logic [1:0]          SelectionTypeTY,
  input  logic [ADDR_W-1:0]   NextAddressNA,
  input  logic [OPCODE_W-1:0] OpcodeIR,
  input  logic [3:0]          ConditionFlags,
  input  logic [1:0]          ConditionSelect,
  input  logic                MemRequest,
  input  logic                MemReady,
  input  logic                HaltRequest,
`ifdef MSEQ_SINGLE_STEP_EN
  input  logic                StepReq,
`endif
  output logic [ADDR_W-1:0]   ControlAddress,
  output logic [ADDR_W-1:0]   CurrentAddress,
  output logic                MicroValid,
  output logic                Halted,
  output logic                IllegalOpcode,
  output logic [1:0]          StateDebug
);

  seqState_e         state;
  seqState_e         stateNext;
  logic [ADDR_W-1:0] car;
  logic [ADDR_W-1:0] nextSel;
  logic [ADDR_W-1:0] dispatchAddr;
  logic              dispatchValid;
  logic              dispatchSel;
  logic              memStall;
  logic              takeNext;
  logic              stepOk;
  selType_e          selType;

  assign selType = selType_e'(SelectionTypeTY);

`ifdef MSEQ_SINGLE_STEP_EN
  assign stepOk = StepReq;
`else
  assign stepOk = 1'b1;
`endif

  opcode_dispatch_map uDispatch (
    .Opcode          (OpcodeIR),
    .DispatchAddress (dispatchAddr),
    .DispatchValid   (dispatchValid)
  );

  always_comb begin
    nextSel     = incAddr(car);
    dispatchSel = 1'b0;
    case (selType)
      TY_NA:       nextSel = NextAddressNA;
      TY_COND:     nextSel = ConditionFlags[ConditionSelect] ? NextAddressNA : incAddr(car);
      TY_INC:      nextSel = incAddr(car);
      TY_DISPATCH: begin
        nextSel     = dispatchAddr;
        dispatchSel = 1'b1;
      end
      default:     nextSel = incAddr(car);
    endcase
  end

  assign memStall = MemRequest && !MemReady;

  // Stall wins over halt: a stalled word never reaches the boundary check.
  always_comb begin
    stateNext = state;
    takeNext  = 1'b0;
    case (state)
      ST_PRIME: stateNext = ST_RUN;
      ST_RUN: begin
        if (memStall) begin
          stateNext = ST_STALL;
        end else if (stepOk) begin
          takeNext = 1'b1;
          if (HaltRequest && (nextSel == ADDR_ZERO)) stateNext = ST_HALT;
        end
      end
      ST_STALL: begin
        if (MemReady) begin
          takeNext  = 1'b1;
          stateNext = ST_RUN;
        end
      end
      ST_HALT: begin
        if (!HaltRequest) stateNext = ST_RUN;
      end
      default: stateNext = ST_PRIME;
    endcase
  end

  always_comb begin
    ControlAddress = takeNext ? nextSel : car;
    MicroValid     = takeNext;
    IllegalOpcode  = takeNext && dispatchSel && !dispatchValid;
    Halted         = (state == ST_HALT);
  end

  always_ff @(posedge ClockInput or negedge ResetInputN) begin
    if (!ResetInputN) begin
      state <= ST_PRIME;
      car   <= ADDR_ZERO;
    end else begin
      state <= stateNext;
      car   <= ControlAddress;
    end
  end

  assign CurrentAddress = car;
  assign StateDebug     = state;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed vector table with mid-operation resets,
// then randomized cycles checked against a behavioural sequencing model.
module tb_micro_sequencer;

  localparam int W = 15;

  typedef struct {
    logic       rst;
    logic [1:0] ty;
    logic [5:0] na;
    logic [3:0] op;
    logic [3:0] flags;
    logic [1:0] csel;
    logic       mreq;
    logic       mrdy;
    logic       halt;
    logic [W-1:0] expv;
  } vec_t;

  logic       ClockInput;
  logic       ResetInputN;
  logic [1:0] SelectionTypeTY;
  logic [5:0] NextAddressNA;
  logic [3:0] OpcodeIR;
  logic [3:0] ConditionFlags;
  logic [1:0] ConditionSelect;
  logic       MemRequest;
  logic       MemReady;
  logic       HaltRequest;
  logic       StepReq;
  logic [5:0] ControlAddress;
  logic [5:0] CurrentAddress;
  logic       MicroValid;
  logic       Halted;
  logic       IllegalOpcode;
  logic [1:0] StateDebug;

  micro_sequencer dut (
    .ClockInput      (ClockInput),
    .ResetInputN     (ResetInputN),
    .SelectionTypeTY (SelectionTypeTY),
    .NextAddressNA   (NextAddressNA),
    .OpcodeIR        (OpcodeIR),
    .ConditionFlags  (ConditionFlags),
    .ConditionSelect (ConditionSelect),
    .MemRequest      (MemRequest),
    .MemReady        (MemReady),
    .HaltRequest     (HaltRequest),
`ifdef MSEQ_SINGLE_STEP_EN
    .StepReq         (StepReq),
`endif
    .ControlAddress  (ControlAddress),
    .CurrentAddress  (CurrentAddress),
    .MicroValid      (MicroValid),
    .Halted          (Halted),
    .IllegalOpcode   (IllegalOpcode),
    .StateDebug      (StateDebug)
  );

  // Clock / reset
  initial ClockInput = 1'b0;
  always #5 ClockInput = ~ClockInput;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int vectorsApplied = 0;
  int miscompares = 0;

  // Reference model state
  int mCar;
  bit mPrime, mHalt, mStall;

  function automatic logic [W-1:0] packExp(int ctrl, int cur, bit v, bit h, bit ill);
    return {ill, h, v, 6'(cur), 6'(ctrl)};
  endfunction

  function automatic vec_t mkVec(bit rst, int ty, int na, int op, int flags, int csel,
                                 bit mreq, bit mrdy, bit halt,
                                 int ctrl, int cur, bit v, bit h, bit ill);
    vec_t r;
    r.rst = rst; r.ty = 2'(ty); r.na = 6'(na); r.op = 4'(op); r.flags = 4'(flags);
    r.csel = 2'(csel); r.mreq = mreq; r.mrdy = mrdy; r.halt = halt;
    r.expv = packExp(ctrl, cur, v, h, ill);
    return r;
  endfunction

  task automatic checkOut(input string name);
    logic [W-1:0] e, a;
    e = exp_q.pop_front();
    a = {IllegalOpcode, Halted, MicroValid, CurrentAddress, ControlAddress};
    vectorsApplied++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got ctrl=%0d car=%0d valid=%0b halted=%0b illegal=%0b, required ctrl=%0d car=%0d valid=%0b halted=%0b illegal=%0b",
               name, a[5:0], a[11:6], a[12], a[13], a[14], e[5:0], e[11:6], e[12], e[13], e[14]);
    end
  endtask

  // Driver tasks
  task automatic driveInputs(input vec_t v);
    SelectionTypeTY = v.ty;
    NextAddressNA   = v.na;
    OpcodeIR        = v.op;
    ConditionFlags  = v.flags;
    ConditionSelect = v.csel;
    MemRequest      = v.mreq;
    MemReady        = v.mrdy;
    HaltRequest     = v.halt;
  endtask

  // Asserts reset mid-cycle (asynchronously), checks outputs, releases just after a rising edge.
  task automatic resetPulse(input string name, input logic [W-1:0] expv);
    @(negedge ClockInput);
    #3 ResetInputN = 1'b0;
    #1;
    exp_q.push_back(expv);
    checkOut(name);
    @(posedge ClockInput);
    #2 ResetInputN = 1'b1;
  endtask

  task automatic applyVec(input vec_t v, input string name);
    if (v.rst) begin
      resetPulse(name, v.expv);
    end else begin
      @(negedge ClockInput);
      driveInputs(v);
      #1;
      exp_q.push_back(v.expv);
      checkOut(name);
    end
  endtask

  // Behavioural model: computes the committed address from the sequencing rules.
  task automatic modelStep(input vec_t v, output logic [W-1:0] e);
    int incr, nxt, ctrl;
    bit valid, ill, cand, halted;
    incr = (mCar + 1) % 64;
    case (v.ty)
      2'd0: nxt = v.na;
      2'd1: nxt = v.flags[v.csel] ? int'(v.na) : incr;
      2'd2: nxt = incr;
      default: nxt = (v.op < 12) ? 8 + 2 * int'(v.op) : 0;
    endcase
    cand = (v.ty == 2'd3) && (v.op >= 12);
    ctrl = mCar; valid = 0; ill = 0; halted = mHalt;
    if (mPrime) begin
      mPrime = 0;
    end else if (mHalt) begin
      if (!v.halt) mHalt = 0;
    end else if (mStall) begin
      if (v.mrdy) begin
        ctrl = nxt; valid = 1; ill = cand; mStall = 0;
      end
    end else if (v.mreq && !v.mrdy) begin
      mStall = 1;
    end else begin
      ctrl = nxt; valid = 1; ill = cand;
      if (v.halt && nxt == 0) mHalt = 1;
    end
    e = packExp(ctrl, mCar, valid, halted, ill);
    mCar = ctrl;
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [W-1:0] e;
    ResetInputN = 1'b0;
    StepReq = 1'b1;
    driveInputs(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //            rst ty na op  flg cs mq mr ht  ctrl cur v h i
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0)); // reset
    vecs.push_back(mkVec(0, 0, 21, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // PRIME
    vecs.push_back(mkVec(0, 0, 21, 0, 0, 0, 0, 0, 0, 21, 0, 1, 0, 0)); // RUN at 0
    vecs.push_back(mkVec(0, 1, 22, 0, 1, 0, 0, 0, 0, 22, 21, 1, 0, 0)); // cond Z=1 -> NA
    vecs.push_back(mkVec(0, 0, 21, 0, 0, 0, 0, 0, 0, 21, 22, 1, 0, 0));
    vecs.push_back(mkVec(0, 1, 22, 0, 0, 0, 0, 0, 0, 22, 21, 1, 0, 0)); // cond Z=0 -> CAR+1
    vecs.push_back(mkVec(0, 0, 63, 0, 0, 0, 0, 0, 0, 63, 22, 1, 0, 0));
    vecs.push_back(mkVec(0, 2, 0, 0, 0, 0, 0, 0, 0,  0, 63, 1, 0, 0)); // 63 wraps
    vecs.push_back(mkVec(0, 3, 0, 3, 0, 0, 0, 0, 0, 14,  0, 1, 0, 0)); // dispatch op 3
    vecs.push_back(mkVec(0, 3, 0, 13, 0, 0, 0, 0, 0, 0, 14, 1, 0, 1)); // unmapped op
    vecs.push_back(mkVec(0, 0, 5, 0, 0, 0, 0, 0, 0,  5,  0, 1, 0, 0));
    vecs.push_back(mkVec(0, 0, 7, 0, 0, 0, 1, 0, 0,  5,  5, 0, 0, 0)); // stall 1
    vecs.push_back(mkVec(0, 0, 7, 0, 0, 0, 1, 0, 0,  5,  5, 0, 0, 0)); // stall 2
    vecs.push_back(mkVec(0, 0, 7, 0, 0, 0, 1, 0, 0,  5,  5, 0, 0, 0)); // stall 3
    vecs.push_back(mkVec(0, 0, 7, 0, 0, 0, 1, 1, 0,  7,  5, 1, 0, 0)); // ready
    vecs.push_back(mkVec(0, 0, 5, 0, 0, 0, 0, 0, 0,  5,  7, 1, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0,  5, 1, 0, 0)); // halt boundary
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 1, 0)); // halted
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0)); // release
    vecs.push_back(mkVec(0, 0, 9, 0, 0, 0, 0, 0, 0,  9,  0, 1, 0, 0)); // running again
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 1, 0, 1,  9,  9, 0, 0, 0)); // stall beats halt
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 1, 1, 1,  0,  9, 1, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0,  0, 1, 0, 0)); // next boundary halts
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 0, 0, 0, 0,  1,  0, 1, 0, 0));
    vecs.push_back(mkVec(0, 0, 10, 0, 0, 0, 1, 0, 0, 1,  1, 0, 0, 0)); // enter stall
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0)); // reset mid-stall
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0)); // PRIME ignores halt
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0,  0, 1, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 1, 0)); // halted
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0)); // reset mid-halt
    vecs.push_back(mkVec(0, 0, 3, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0)); // PRIME
    vecs.push_back(mkVec(0, 0, 3, 0, 0, 0, 0, 0, 0,  3,  0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], $sformatf("vec%0d", i));

    // Randomized phase against the reference model
    resetPulse("rand_reset", packExp(0, 0, 0, 0, 0));
    mCar = 0; mPrime = 1; mHalt = 0; mStall = 0;
    for (int n = 0; n < 600; n++) begin
      v.rst   = 0;
      v.ty    = 2'($urandom_range(0, 3));
      v.na    = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      v.op    = 4'($urandom_range(0, 15));
      v.flags = 4'($urandom_range(0, 15));
      v.csel  = 2'($urandom_range(0, 3));
      v.mreq  = ($urandom_range(0, 2) == 0);
      v.mrdy  = ($urandom_range(0, 1) == 0);
      v.halt  = ($urandom_range(0, 2) == 0);
      v.expv  = '0;
      @(negedge ClockInput);
      driveInputs(v);
      #1;
      modelStep(v, e);
      exp_q.push_back(e);
      checkOut($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
